md_seq_ctrl: RTL and testbench
==============================

// Module: md_seq_ctrl
// PURPOSE
//  Sequencer for the CPU's multiply/divide resource. Decodes the 3-bit mul_div_control op, launches
//  the fixed-latency multiplier pipe or the handshaked iterative divider, and stalls the PC through
//  pc_ena until the result is ready. It owns the architectural HI/LO registers and flags MUL write-back.
// PARAMETERS
//  MUL_LAT      2    multiplier pipe latency in cycles, >=1; mul_p valid MUL_LAT cycles after accept
//  DIV_TIMEOUT  64   max DIV_WAIT cycles before abort, >=2
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  md_op      in   3   000 NONE,001 MULT,010 MULTU,011 DIV,100 DIVU,101 MTHI,110 MTLO,111 MUL
//  rs_data    in   32  rs operand; held stable by the stalled instruction
//  rt_data    in   32  rt operand
//  mul_p      in   64  multiplier pipe output
//  mul_signed out  1   1 for MULT/MUL, 0 otherwise
//  div_start  out  1   one-cycle launch pulse to divider
//  div_signed out  1   1 for DIV, 0 for DIVU; valid with div_start
//  div_abort  out  1   one-cycle pulse on timeout
//  div_done   in   1   divider result valid this cycle
//  div_q      in   32  quotient
//  div_r      in   32  remainder
//  pc_ena     out  1   0 = hold PC/instruction this cycle
//  hi         out  32  HI register
//  lo         out  32  LO register
//  mul_out    out  32  mul_p[31:0], combinational
//  mul_wb     out  1   1 in MUL completion cycle; ControlUnit writes mul_out to rd
//  md_busy    out  1   state != IDLE
//  div_err    out  1   sticky divider-timeout flag
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE; hi=lo=0; div_err=0; counters=0.
//   While rst_n is asserted, pc_ena=1 and div_start=div_abort=mul_wb=0, regardless of md_op.
//   Reset mid-operation discards the operation with no HI/LO write.
//  States: IDLE, MUL_WAIT, DIV_WAIT.
//  IDLE:
//   NONE: pc_ena=1.
//   MTHI/MTLO: pc_ena=1; hi (or lo) <= rs_data at the edge.
//   MULT/MULTU/MUL: pc_ena=0; cnt <= MUL_LAT-1; go to MUL_WAIT.
//   DIV/DIVU with rt_data!=0: div_start=1, pc_ena=0; dcnt <= 0; go to DIV_WAIT.
//   DIV/DIVU with rt_data==0: no start, pc_ena=1; hi <= rs_data, lo <= 32'hFFFFFFFF.
//  MUL_WAIT:
//   cnt!=0: pc_ena=0; cnt decrements.
//   cnt==0: pc_ena=1. MULT/MULTU: {hi,lo} <= mul_p. MUL: mul_wb=1 and HI/LO unchanged.
//    Go to IDLE. Each mult instruction occupies MUL_LAT+1 cycles.
//  DIV_WAIT:
//   div_done=1: pc_ena=1; lo <= div_q, hi <= div_r; go to IDLE.
//   div_done=0 and dcnt==DIV_TIMEOUT-1: pc_ena=1, div_abort=1; hi=lo <= 0; div_err <= 1; go to IDLE.
//   Otherwise: pc_ena=0; dcnt increments.
//  Ignored inputs: div_done in IDLE, MUL_WAIT, or the div_start cycle. md_op is sampled only in IDLE.
//  The instruction is held by pc_ena=0, so the completion edge advances the PC and no op relaunches.
//  Timeout wins over nothing: div_done on the final allowed cycle is a normal completion.
//  div_err clears only on reset.
// TESTING
//  1 MULT rs=0xFFFFFFFF rt=2, MUL_LAT=2 -> pc_ena 0,0,1; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2 MUL rs=7 rt=6 -> mul_wb=1 and mul_out=42 in the completion cycle only; hi/lo unchanged.
//  3 DIVU rs=100 rt=7, divider done after 33 cycles -> single div_start pulse, pc_ena low until done;
//    then lo=14, hi=2.
//  4 DIV rt=0 -> no div_start, pc_ena stays 1; hi=rs, lo=0xFFFFFFFF.
//    Also: MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi=0x1234, lo=0x5678, no stall.
//  5 DIV with div_done never asserted -> abort at cycle DIV_TIMEOUT; div_err=1, hi=lo=0.
//    rst_n pulse mid-MULT -> IDLE, pc_ena=1, hi=lo=0, div_err=0.

Source files
------------

// File: rtl/md_seq_ctrl_if.sv
// Signal bundle between the multiply/divide sequencer and its surroundings
// (decode, operand buses, multiplier pipe, iterative divider, HI/LO results).
interface md_seq_ctrl_if;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [63:0] mul_p;
  logic        mul_signed;
  logic        div_start;
  logic        div_signed;
  logic        div_abort;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        pc_ena;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_out;
  logic        mul_wb;
  logic        md_busy;
  logic        div_err;

  // The sequencer is the slave; the CPU core, multiplier and divider form the master side.
  modport slave (
    input  md_op, rs_data, rt_data, mul_p, div_done, div_q, div_r,
    output mul_signed, div_start, div_signed, div_abort,
           pc_ena, hi, lo, mul_out, mul_wb, md_busy, div_err
  );

  modport master (
    output md_op, rs_data, rt_data, mul_p, div_done, div_q, div_r,
    input  mul_signed, div_start, div_signed, div_abort,
           pc_ena, hi, lo, mul_out, mul_wb, md_busy, div_err
  );
endinterface

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer: launches the fixed-latency multiplier or the handshaked
// divider, stalls the PC until the result lands, and owns the HI/LO registers.
module md_seq_ctrl #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  md_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2
  } state_e;

  localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int DCNT_W = $clog2(DIV_TIMEOUT);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DIV_TIMEOUT - 1);

  op_e               op;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              is_mul_q, is_mul_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              err_q, err_d;

  logic              pc_ena;
  logic              div_start;
  logic              div_abort;
  logic              mul_wb;

  assign op = op_e'(bus.md_op);

  // Operand signedness follows the held instruction, so it stays valid for the whole operation.
  assign bus.mul_signed = (op == OP_MULT) || (op == OP_MUL);
  assign bus.div_signed = (op == OP_DIV);
  assign bus.mul_out    = bus.mul_p[31:0];
  assign bus.md_busy    = (state_q != S_IDLE);
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.div_err    = err_q;
  assign bus.pc_ena     = pc_ena;
  assign bus.div_start  = div_start;
  assign bus.div_abort  = div_abort;
  assign bus.mul_wb     = mul_wb;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    is_mul_d  = is_mul_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    pc_ena    = 1'b1;
    div_start = 1'b0;
    div_abort = 1'b0;
    mul_wb    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        unique case (op)
          OP_MTHI: hi_d = bus.rs_data;
          OP_MTLO: lo_d = bus.rs_data;
          OP_MULT, OP_MULTU, OP_MUL: begin
            pc_ena   = 1'b0;
            cnt_d    = CNT_LOAD;
            is_mul_d = (op == OP_MUL);
            state_d  = S_MUL_WAIT;
          end
          OP_DIV, OP_DIVU: begin
            if (bus.rt_data != 32'd0) begin
              div_start = 1'b1;
              pc_ena    = 1'b0;
              dcnt_d    = '0;
              state_d   = S_DIV_WAIT;
            end else begin
              // Divide by zero resolves immediately without touching the divider.
              hi_d = bus.rs_data;
              lo_d = '1;
            end
          end
          default: ;
        endcase
      end

      S_MUL_WAIT: begin
        if (cnt_q != '0) begin
          pc_ena = 1'b0;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          if (is_mul_q) begin
            mul_wb = 1'b1;
          end else begin
            hi_d = bus.mul_p[63:32];
            lo_d = bus.mul_p[31:0];
          end
          state_d = S_IDLE;
        end
      end

      S_DIV_WAIT: begin
        // A result on the last allowed cycle takes priority over the timeout.
        if (bus.div_done) begin
          lo_d    = bus.div_q;
          hi_d    = bus.div_r;
          state_d = S_IDLE;
        end else if (dcnt_q == DCNT_MAX) begin
          div_abort = 1'b1;
          hi_d      = '0;
          lo_d      = '0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          pc_ena = 1'b0;
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Reset is asynchronous, so the decode above must not leak stalls or pulses while it is held.
    if (!rst_n) begin
      pc_ena    = 1'b1;
      div_start = 1'b0;
      div_abort = 1'b0;
      mul_wb    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      is_mul_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      is_mul_q <= is_mul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: a small multiplier pipe model plus hand-driven divider
// handshakes, with every expected value written out in the stimulus.
module tb_md_seq_ctrl;
  localparam int MUL_LAT     = 2;
  localparam int DIV_TIMEOUT = 64;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;
  localparam logic [2:0] MUL   = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  md_seq_ctrl_if bus();

  md_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Multiplier pipe model: the product appears on mul_p MUL_LAT cycles after it is sampled.
  logic [63:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    pipe[0] <= mul64(bus.mul_signed, bus.rs_data, bus.rt_data);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_p = pipe[MUL_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.md_op   = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.div_done = 1'b0;
    bus.div_q   = '0;
    bus.div_r   = '0;
    drive(MULT, 32'd3, 32'd4);

    // Reset: outputs forced regardless of the op on the bus.
    @(negedge clk);
    check("rst_pc_ena_mult", bus.pc_ena, 1);
    check("rst_busy", bus.md_busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_div_err", bus.div_err, 0);
    drive(DIV, 32'd9, 32'd5);
    #1;
    check("rst_div_start", bus.div_start, 0);
    check("rst_pc_ena_div", bus.pc_ena, 1);
    drive(NONE, 0, 0);
    tick();
    rst_n = 1'b1;

    // MTHI then MTLO back-to-back, no stall.
    drive(MTHI, 32'h1234, 0);
    @(negedge clk);
    check("mthi_pc_ena", bus.pc_ena, 1);
    tick();
    check("mthi_hi", bus.hi, 32'h1234);
    drive(MTLO, 32'h5678, 0);
    @(negedge clk);
    check("mtlo_pc_ena", bus.pc_ena, 1);
    tick();
    check("mtlo_lo", bus.lo, 32'h5678);
    check("mtlo_hi_kept", bus.hi, 32'h1234);

    // MULT 0xFFFFFFFF * 2 signed = -2.
    drive(MULT, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    check("mult_c0_pc_ena", bus.pc_ena, 0);
    check("mult_signed", bus.mul_signed, 1);
    tick();
    @(negedge clk);
    check("mult_c1_pc_ena", bus.pc_ena, 0);
    check("mult_c1_busy", bus.md_busy, 1);
    tick();
    @(negedge clk);
    check("mult_c2_pc_ena", bus.pc_ena, 1);
    check("mult_c2_mul_wb", bus.mul_wb, 0);
    tick();
    drive(NONE, 0, 0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFE);
    check("mult_idle", bus.md_busy, 0);

    // MULTU 0xFFFFFFFF * 2 unsigned = 0x1_FFFFFFFE.
    drive(MULTU, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    check("multu_signed", bus.mul_signed, 0);
    tick();
    tick();
    tick();
    drive(NONE, 0, 0);
    check("multu_hi", bus.hi, 32'h1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // MUL 7*6: write-back flag only in the completion cycle, HI/LO untouched.
    drive(MUL, 32'd7, 32'd6);
    @(negedge clk);
    check("mul_c0_pc_ena", bus.pc_ena, 0);
    check("mul_c0_wb", bus.mul_wb, 0);
    tick();
    @(negedge clk);
    check("mul_c1_wb", bus.mul_wb, 0);
    tick();
    @(negedge clk);
    check("mul_c2_wb", bus.mul_wb, 1);
    check("mul_c2_out", bus.mul_out, 32'd42);
    check("mul_c2_pc_ena", bus.pc_ena, 1);
    tick();
    drive(NONE, 0, 0);
    @(negedge clk);
    check("mul_after_wb", bus.mul_wb, 0);
    check("mul_hi_kept", bus.hi, 32'h1);
    check("mul_lo_kept", bus.lo, 32'hFFFF_FFFE);

    // DIV by zero: immediate, no divider launch.
    drive(DIV, 32'hCAFE_0000, 32'd0);
    @(negedge clk);
    check("div0_start", bus.div_start, 0);
    check("div0_pc_ena", bus.pc_ena, 1);
    tick();
    drive(NONE, 0, 0);
    check("div0_hi", bus.hi, 32'hCAFE_0000);
    check("div0_lo", bus.lo, 32'hFFFF_FFFF);
    check("div0_busy", bus.md_busy, 0);

    // DIVU 100/7 with the divider finishing 32 wait cycles after launch.
    drive(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    check("divu_start", bus.div_start, 1);
    check("divu_signed", bus.div_signed, 0);
    check("divu_pc_ena", bus.pc_ena, 0);
    tick();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("divu_wait", {bus.pc_ena, bus.div_start, bus.div_abort}, 3'b000);
      tick();
    end
    bus.div_done = 1'b1;
    bus.div_q    = 32'd14;
    bus.div_r    = 32'd2;
    @(negedge clk);
    check("divu_done_pc_ena", bus.pc_ena, 1);
    tick();
    bus.div_done = 1'b0;
    drive(NONE, 0, 0);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    check("divu_idle", bus.md_busy, 0);

    // Stray div_done in IDLE is ignored.
    bus.div_done = 1'b1;
    bus.div_q    = 32'hDEAD;
    bus.div_r    = 32'hBEEF;
    tick();
    bus.div_done = 1'b0;
    check("stray_done_lo", bus.lo, 32'd14);
    check("stray_done_hi", bus.hi, 32'd2);

    // DIV with no completion: abort on the DIV_TIMEOUT-th wait cycle.
    drive(DIV, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    check("divto_start", bus.div_start, 1);
    check("divto_signed", bus.div_signed, 1);
    tick();
    for (int i = 0; i < DIV_TIMEOUT - 1; i++) begin
      @(negedge clk);
      check("divto_wait", {bus.pc_ena, bus.div_start, bus.div_abort}, 3'b000);
      tick();
    end
    @(negedge clk);
    check("divto_abort", bus.div_abort, 1);
    check("divto_pc_ena", bus.pc_ena, 1);
    tick();
    drive(NONE, 0, 0);
    check("divto_hi", bus.hi, 0);
    check("divto_lo", bus.lo, 0);
    check("divto_err", bus.div_err, 1);
    check("divto_idle", bus.md_busy, 0);
    @(negedge clk);
    check("divto_abort_pulse", bus.div_abort, 0);

    // Completion on the final allowed cycle is normal; div_err stays sticky.
    drive(DIV, 32'd53, 32'd5);
    tick();
    for (int i = 0; i < DIV_TIMEOUT - 1; i++) tick();
    bus.div_done = 1'b1;
    bus.div_q    = 32'd10;
    bus.div_r    = 32'd3;
    @(negedge clk);
    check("divlast_no_abort", bus.div_abort, 0);
    check("divlast_pc_ena", bus.pc_ena, 1);
    tick();
    bus.div_done = 1'b0;
    drive(NONE, 0, 0);
    check("divlast_lo", bus.lo, 32'd10);
    check("divlast_hi", bus.hi, 32'd3);
    check("divlast_err_sticky", bus.div_err, 1);

    // Reset mid-MULT: operation discarded, everything back to reset values.
    drive(MULT, 32'd3, 32'd4);
    tick();
    check("mid_mult_busy", bus.md_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_pc_ena", bus.pc_ena, 1);
    check("rstmid_busy", bus.md_busy, 0);
    check("rstmid_hi", bus.hi, 0);
    check("rstmid_lo", bus.lo, 0);
    check("rstmid_err", bus.div_err, 0);
    tick();
    @(negedge clk);
    check("rstmid_hold_pc_ena", bus.pc_ena, 1);
    check("rstmid_hold_wb", bus.mul_wb, 0);
    drive(NONE, 0, 0);
    rst_n = 1'b1;
    tick();
    check("rstmid_after_busy", bus.md_busy, 0);
    check("rstmid_after_hi", bus.hi, 0);
    check("rstmid_after_lo", bus.lo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
